// File: rtl/board_state.sv
// 8x8 board storage with a 4-bit piece code per cell: reloads the start position,
// moves codes between cells, and tracks king capture. Read port is registered.
module board_state #(
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init_req,
    input  logic [2:0] rd_x,
    input  logic [2:0] rd_y,
    output logic [3:0] rd_piece,
    input  logic       move_req,
    input  logic [2:0] src_x,
    input  logic [2:0] src_y,
    input  logic [2:0] dst_x,
    input  logic [2:0] dst_y,
    output logic       busy,
    output logic       init_done,
    output logic       move_done,
    output logic       move_err,
    output logic [3:0] captured,
    output logic       king_taken,
    output logic       winner
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_MOVE_READ,
        S_MOVE_WRITE,
        S_MOVE_CLEAR,
        S_DONE
    } state_t;

    state_t     state;
    logic [3:0] cells [64];
    logic [5:0] init_cnt;
    logic [5:0] src_idx;
    logic [5:0] dst_idx;
    logic [3:0] src_code;
    logic [3:0] dst_code;

    logic       we;
    logic [5:0] waddr;
    logic [3:0] wdata;

    // Back rank is shared by both colours; white codes are black codes + 6.
    function automatic logic [3:0] start_piece(input logic [5:0] idx);
        logic [3:0] back;
        case (idx[2:0])
            3'd0, 3'd7: back = 4'd4;
            3'd1, 3'd6: back = 4'd2;
            3'd2, 3'd5: back = 4'd3;
            3'd3:       back = 4'd5;
            default:    back = 4'd6;
        endcase
        case (idx[5:3])
            3'd0:    return back;
            3'd1:    return 4'd1;
            3'd6:    return 4'd7;
            3'd7:    return back + 4'd6;
            default: return 4'd0;
        endcase
    endfunction

    always_comb begin
        we    = 1'b0;
        waddr = init_cnt;
        wdata = start_piece(init_cnt);
        case (state)
            S_INIT: we = 1'b1;
            S_MOVE_WRITE: begin
                we    = 1'b1;
                waddr = dst_idx;
                wdata = src_code;
            end
            S_MOVE_CLEAR: begin
                we    = 1'b1;
                waddr = src_idx;
                wdata = 4'd0;
            end
            default: we = 1'b0;
        endcase
        // A reset edge must not complete a pending write.
        if (reset)
            we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (we)
            cells[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= INIT_ON_RESET ? S_INIT : S_IDLE;
            init_cnt   <= '0;
            src_idx    <= '0;
            dst_idx    <= '0;
            src_code   <= '0;
            dst_code   <= '0;
            rd_piece   <= '0;
            busy       <= 1'b0;
            init_done  <= 1'b0;
            move_done  <= 1'b0;
            move_err   <= 1'b0;
            captured   <= '0;
            king_taken <= 1'b0;
            winner     <= 1'b0;
        end else begin
            rd_piece  <= cells[{rd_y, rd_x}];
            init_done <= 1'b0;
            move_done <= 1'b0;
            move_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (init_req) begin
                        state      <= S_INIT;
                        init_cnt   <= '0;
                        king_taken <= 1'b0;
                        winner     <= 1'b0;
                        busy       <= 1'b1;
                    end else if (move_req) begin
                        state   <= S_MOVE_READ;
                        src_idx <= {src_y, src_x};
                        dst_idx <= {dst_y, dst_x};
                        busy    <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_INIT: begin
                    init_cnt <= init_cnt + 6'd1;
                    if (init_cnt == 6'd63) begin
                        state     <= S_IDLE;
                        init_done <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        busy <= 1'b1;
                    end
                end
                S_MOVE_READ: begin
                    src_code <= cells[src_idx];
                    dst_code <= cells[dst_idx];
                    if (src_idx == dst_idx || cells[src_idx] == 4'd0) begin
                        state    <= S_IDLE;
                        move_err <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        state <= S_MOVE_WRITE;
                        busy  <= 1'b1;
                    end
                end
                S_MOVE_WRITE: begin
                    captured <= dst_code;
                    state    <= S_MOVE_CLEAR;
                    busy     <= 1'b1;
                end
                S_MOVE_CLEAR: begin
                    state <= S_DONE;
                    busy  <= 1'b1;
                end
                S_DONE: begin
                    move_done <= 1'b1;
                    if (!king_taken && (captured == 4'd6 || captured == 4'd12)) begin
                        king_taken <= 1'b1;
                        winner     <= (src_code >= 4'd7);
                    end
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_state.sv
// Scoreboard bench for board_state: stimulus pushes expected events and reads,
// a negedge monitor pops and compares them against the DUT.
module tb_board_state;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       init_req = 1'b0;
    logic       move_req = 1'b0;
    logic [2:0] rd_x = '0, rd_y = '0;
    logic [2:0] src_x = '0, src_y = '0, dst_x = '0, dst_y = '0;
    logic [3:0] rd_piece, captured;
    logic       busy, init_done, move_done, move_err, king_taken, winner;

    always #5 clk = ~clk;

    board_state #(.INIT_ON_RESET(1'b1)) dut (
        .clk(clk), .reset(reset), .init_req(init_req),
        .rd_x(rd_x), .rd_y(rd_y), .rd_piece(rd_piece),
        .move_req(move_req), .src_x(src_x), .src_y(src_y),
        .dst_x(dst_x), .dst_y(dst_y), .busy(busy),
        .init_done(init_done), .move_done(move_done), .move_err(move_err),
        .captured(captured), .king_taken(king_taken), .winner(winner)
    );

    typedef struct {
        int kind;  // {init_done, move_done, move_err} as a 3-bit value
        int cyc;
        int cap;
        int kt;
        int win;
    } exp_t;

    exp_t sbq[$];
    int   rdq[$];
    int   model[64];
    int   m_cap = 0, m_kt = 0, m_win = 0;
    int   checks = 0, passes = 0;
    int   cyc = 0;
    logic rd_en = 1'b0, rd_pend = 1'b0;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rd_pend <= rd_en;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int start_code(input int idx);
        int black_back[8] = '{4, 2, 3, 5, 6, 3, 2, 4};
        int white_back[8] = '{10, 8, 9, 11, 12, 9, 8, 10};
        int y = idx / 8;
        int x = idx % 8;
        if (y == 0) return black_back[x];
        if (y == 1) return 1;
        if (y == 6) return 7;
        if (y == 7) return white_back[x];
        return 0;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        int   k;
        int   r;
        if (rd_pend && rdq.size() > 0) begin
            r = rdq.pop_front();
            check("rd_piece", int'(rd_piece), r);
        end
        if (init_done || move_done || move_err) begin
            k = int'({init_done, move_done, move_err});
            if (sbq.size() == 0) begin
                check("spurious_event", k, 0);
            end else begin
                e = sbq.pop_front();
                check("event_kind", k, e.kind);
                check("event_cycle", cyc, e.cyc);
                check("captured", int'(captured), e.cap);
                check("king_taken", int'(king_taken), e.kt);
                check("winner", int'(winner), e.win);
            end
        end
    end

    task automatic push_exp(input int kind, input int at);
        exp_t e;
        e.kind = kind; e.cyc = at; e.cap = m_cap; e.kt = m_kt; e.win = m_win;
        sbq.push_back(e);
    endtask

    task automatic model_start();
        for (int i = 0; i < 64; i++) model[i] = start_code(i);
        m_kt = 0;
        m_win = 0;
    endtask

    // Called at a negedge; holds reset for two edges then expects a full reload.
    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_rd_piece", int'(rd_piece), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_init_done", int'(init_done), 0);
        check("rst_move_done", int'(move_done), 0);
        check("rst_move_err", int'(move_err), 0);
        check("rst_captured", int'(captured), 0);
        check("rst_king_taken", int'(king_taken), 0);
        check("rst_winner", int'(winner), 0);
        reset = 1'b0;
        m_cap = 0;
        model_start();
        push_exp(4, cyc + 64);
        @(negedge clk);
        check("busy_after_reset", int'(busy), 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (sbq.size() == 0 && rdq.size() == 0 && !busy) return;
            @(negedge clk);
        end
        check("wait_idle_timeout", 1, 0);
        sbq.delete();
        rdq.delete();
    endtask

    task automatic issue_init(input bit with_move);
        init_req = 1'b1;
        move_req = with_move;
        src_x = 3'd0; src_y = 3'd6; dst_x = 3'd0; dst_y = 3'd5;
        model_start();
        push_exp(4, cyc + 65);
        @(negedge clk);
        init_req = 1'b0;
        if (with_move) repeat (20) @(negedge clk);
        move_req = 1'b0;
    endtask

    task automatic issue_move(input int sx, input int sy, input int dx, input int dy);
        int si = sy * 8 + sx;
        int di = dy * 8 + dx;
        int piece;
        src_x = 3'(sx); src_y = 3'(sy); dst_x = 3'(dx); dst_y = 3'(dy);
        move_req = 1'b1;
        if (si == di || model[si] == 0) begin
            push_exp(1, cyc + 2);
        end else begin
            piece = model[si];
            m_cap = model[di];
            model[di] = piece;
            model[si] = 0;
            if (m_kt == 0 && (m_cap == 6 || m_cap == 12)) begin
                m_kt = 1;
                m_win = (piece >= 7) ? 1 : 0;
            end
            push_exp(2, cyc + 5);
        end
        @(negedge clk);
        move_req = 1'b0;
    endtask

    task automatic read_cell(input int x, input int y);
        rd_x = 3'(x);
        rd_y = 3'(y);
        rd_en = 1'b1;
        rdq.push_back(model[y * 8 + x]);
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic read_all();
        for (int i = 0; i < 64; i++) read_cell(i % 8, i / 8);
        wait_idle();
    endtask

    function automatic int pick_occupied();
        int occ[$];
        for (int i = 0; i < 64; i++) if (model[i] != 0) occ.push_back(i);
        if (occ.size() == 0) return 0;
        return occ[$urandom_range(occ.size() - 1)];
    endfunction

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int s;
        int d;
        @(negedge clk);
        do_reset();
        wait_idle();
        read_all();

        issue_move(4, 6, 4, 4);
        wait_idle();
        read_cell(4, 4);
        read_cell(4, 6);
        wait_idle();

        issue_move(1, 1, 1, 1);
        wait_idle();
        issue_move(3, 3, 5, 5);
        wait_idle();
        read_all();

        issue_move(3, 7, 4, 0);
        wait_idle();
        read_cell(4, 0);
        wait_idle();

        // init_req and move_req together, then move_req held through the reload.
        issue_init(1'b1);
        wait_idle();
        read_all();

        issue_move(1, 7, 2, 5);
        @(negedge clk);
        src_x = 3'd0; src_y = 3'd1; dst_x = 3'd0; dst_y = 3'd3;
        move_req = 1'b1;
        @(negedge clk);
        move_req = 1'b0;
        wait_idle();
        read_all();

        for (int i = 0; i < 40; i++) begin
            if (i % 10 == 9) begin
                issue_init(1'($urandom_range(1)));
                wait_idle();
            end
            s = ($urandom_range(3) == 0) ? int'($urandom_range(63)) : pick_occupied();
            d = ($urandom_range(7) == 0) ? s : int'($urandom_range(63));
            issue_move(s % 8, s / 8, d % 8, d / 8);
            wait_idle();
            for (int j = 0; j < 3; j++) begin
                d = int'($urandom_range(63));
                read_cell(d % 8, d / 8);
            end
            wait_idle();
        end
        read_all();

        // Abort a move while it is in S_MOVE_WRITE.
        s = pick_occupied();
        d = (s + 9) % 64;
        src_x = 3'(s % 8); src_y = 3'(s / 8); dst_x = 3'(d % 8); dst_y = 3'(d / 8);
        move_req = 1'b1;
        @(negedge clk);
        move_req = 1'b0;
        @(negedge clk);
        do_reset();
        wait_idle();
        read_all();

        repeat (10) @(negedge clk);
        check("final_queue_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/board_state.md
BOARD_STATE -- requirements
Module: board_state

Interface
REQ-001 Parameter: INIT_ON_RESET, default 1, reset enters S_INIT when 1 and S_IDLE when 0.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 init_req  input  1  start-position reload request; sampled in S_IDLE only.
REQ-005 rd_x, rd_y  input  3 each  renderer read column/row, 0..7.
REQ-006 rd_piece  output  4  registered piece code at (rd_x, rd_y), 1-cycle latency.
REQ-007 move_req  input  1  move request; sampled in S_IDLE only.
REQ-008 src_x, src_y, dst_x, dst_y  input  3 each  move source/destination; sampled with move_req.
REQ-009 busy  output  1  high in every state except S_IDLE.
REQ-010 init_done  output  1  one-cycle pulse after the 64th init write.
REQ-011 move_done  output  1  one-cycle pulse when a move completes.
REQ-012 move_err  output  1  one-cycle pulse when a move is rejected.
REQ-013 captured  output  4  prior destination code; valid from move_done until the next move_done or move_err.
REQ-014 king_taken  output  1  sticky; set when captured is 6 or 12; cleared by reset or by init.
REQ-015 winner  output  1  colour of the capturing piece at the king_taken set (0 = black, 1 = white); held while king_taken.

Function
REQ-016 Storage: 64 x 4-bit cells; index = y*8 + x (6 bits, no wrap beyond 63).
REQ-017 Codes: 0 empty; 1-6 black pawn, knight, bishop, rook, queen, king; 7-12 white pawn, knight, bishop, rook, queen, king; 13-15 never written.
REQ-018 States: S_IDLE, S_INIT, S_MOVE_READ, S_MOVE_WRITE, S_MOVE_CLEAR, S_DONE.
REQ-019 S_IDLE: init_req -> S_INIT; else move_req -> S_MOVE_READ; init_req wins when both are high.
REQ-020 S_INIT: 6-bit counter 0..63 writes one cell per cycle; after index 63, init_done pulses and the state goes to S_IDLE (64 cycles in S_INIT).
REQ-021 Start position, y=0: 4,2,3,5,6,3,2,4 for x=0..7.
REQ-022 Start position, y=1: all 1; y=2..5: all 0; y=6: all 7.
REQ-023 Start position, y=7: 10,8,9,11,12,9,8,10 for x=0..7.
REQ-024 S_MOVE_READ: latch coordinates, src code and dst code; if src==dst or src code==0, pulse move_err, leave storage unchanged and return to S_IDLE.
REQ-025 S_MOVE_WRITE: cell[dst] <= latched src code; captured <= latched dst code.
REQ-026 S_MOVE_CLEAR: cell[src] <= 0.
REQ-027 S_DONE: move_done pulses and king_taken/winner update per REQ-014/015; next state S_IDLE.
REQ-028 Move latency: move_req high in S_IDLE at edge N gives move_done high in the cycle after edge N+4.
REQ-029 Error latency: move_err is high in the cycle after edge N+1.
REQ-030 move_req and init_req are ignored while busy; no queuing.
REQ-031 Legality of the chess move is not checked; the block only moves codes.
REQ-032 Read port runs every cycle in every state and returns the storage content at the edge.
REQ-033 Reads during S_INIT or a move may return a mix of old and new cells.

Reset
REQ-034 On reset: rd_piece=0, busy=0 for one cycle then per state, init_done=0, move_done=0, move_err=0, captured=0, king_taken=0, winner=0.
REQ-035 On reset: init counter=0; next state S_INIT if INIT_ON_RESET=1, else S_IDLE.
REQ-036 Reset asserted mid-move or mid-init aborts immediately; no further writes; partially written cells are kept until overwritten by init.

Verification
REQ-037 Reset with INIT_ON_RESET=1 -> init_done after 64 cycles; read all 64 cells -> (0,0)=4, (4,0)=6, (3,7)=11, (2,3)=0, (5,6)=7.
REQ-038 After init, move (4,6)->(4,4) -> move_done 4 cycles after move_req; (4,4)=7, (4,6)=0, captured=0, king_taken=0.
REQ-039 Moves src=dst=(1,1), then src=(3,3) (empty) -> move_err each time, storage unchanged, no move_done.
REQ-040 Move (3,7)->(4,0) -> captured=6, king_taken=1, winner=1; an init_req then clears king_taken.
REQ-041 move_req held during S_INIT, and a second move_req during a move -> both ignored; exactly one move_done for the accepted move.
REQ-042 Reset asserted while in S_MOVE_WRITE -> all outputs 0 the next cycle; re-init restores the start position.
